// File: rtl/mem_responder.sv
// Memory-side endpoint of the delayed memory bus: a 2^n x m word array with
// single-cycle read/write acknowledge, multi-cycle clear sweeps and a sticky drop flag.
module mem_responder #(
   parameter int n = 8,
   parameter int m = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [n-1:0] marI,
   input  logic [m-1:0] dataI,
   input  logic         ceI,
   input  logic         rwI,
   input  logic         clrI,
   output logic [m-1:0] dataO,
   output logic         ackO,
   output logic         busyO,
   output logic         errO
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam int DEPTH = 1 << n;
   localparam logic [n-1:0] PTR_ONE  = 1;
   localparam logic [n-1:0] PTR_LAST = '1;

   state_t         state_q, state_d;
   logic [n-1:0]   ptr_q, ptr_d;
   logic [m-1:0]   data_q, data_d;
   logic           ack_q, ack_d;
   logic           err_q, err_d;

   logic [m-1:0]   mem_q [0:DEPTH-1];
   logic           mem_we;
   logic [n-1:0]   mem_addr;
   logic [m-1:0]   mem_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         data_q  <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // The array itself has no reset; the forced sweep after reset zeroes it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_addr] <= mem_wdata;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      data_d    = data_q;
      ack_d     = 1'b0;
      err_d     = err_q;
      mem_we    = 1'b0;
      mem_addr  = ptr_q;
      mem_wdata = '0;

      unique case (state_q)
         CLEAR: begin
            if (ceI) begin
               err_d = 1'b1;
            end
            if (clrI) begin
               ptr_d = '0;
            end else begin
               mem_we = 1'b1;
               ptr_d  = ptr_q + PTR_ONE;
               if (ptr_q == PTR_LAST) begin
                  state_d = IDLE;
               end
            end
         end
         IDLE: begin
            if (clrI) begin
               state_d = CLEAR;
               ptr_d   = '0;
               if (ceI) begin
                  err_d = 1'b1;
               end
            end else if (ceI) begin
               ack_d = 1'b1;
               if (rwI) begin
                  data_d = mem_q[marI];
               end else begin
                  mem_we    = 1'b1;
                  mem_addr  = marI;
                  mem_wdata = dataI;
               end
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   assign dataO = data_q;
   assign ackO  = ack_q;
   assign busyO = (state_q == CLEAR);
   assign errO  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a vector table and hand-built corner sequences,
// with expected outputs queued at drive time and compared after each edge.
module tb_mem_responder;

   logic         clk;
   logic         rst_n;
   logic [7:0]   marI;
   logic [31:0]  dataI;
   logic         ceI;
   logic         rwI;
   logic         clrI;
   logic [31:0]  dataO;
   logic         ackO;
   logic         busyO;
   logic         errO;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        ce;
      logic        rw;
      logic [7:0]  mar;
      logic [31:0] data;
      logic        expAck;
      logic [31:0] expData;
   } vec_t;

   typedef struct {
      string       name;
      logic        ack;
      logic [31:0] data;
      logic        busy;
      logic        err;
   } exp_t;

   vec_t vecs [20];
   exp_t sbq [$];

   mem_responder #(.n(8), .m(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .marI  (marI),
      .dataI (dataI),
      .ceI   (ceI),
      .rwI   (rwI),
      .clrI  (clrI),
      .dataO (dataO),
      .ackO  (ackO),
      .busyO (busyO),
      .errO  (errO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one request, queue its expected outcome, and let one rising edge pass.
   task automatic applyStimulus(input string name, input logic ce, input logic rw, input logic clr,
                                input logic [7:0] mar, input logic [31:0] data,
                                input logic expAck, input logic [31:0] expData,
                                input logic expBusy, input logic expErr);
      exp_t e;
      ceI   = ce;
      rwI   = rw;
      clrI  = clr;
      marI  = mar;
      dataI = data;
      e.name = name;
      e.ack  = expAck;
      e.data = expData;
      e.busy = expBusy;
      e.err  = expErr;
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue expected entry");
      end else begin
         e = sbq.pop_front();
         checkVal({e.name, ".ack"},  {31'b0, ackO},  {31'b0, e.ack});
         checkVal({e.name, ".data"}, dataO,          e.data);
         checkVal({e.name, ".busy"}, {31'b0, busyO}, {31'b0, e.busy});
         checkVal({e.name, ".err"},  {31'b0, errO},  {31'b0, e.err});
      end
   endtask

   task automatic idleInputs();
      ceI   = 1'b0;
      rwI   = 1'b0;
      clrI  = 1'b0;
      marI  = 8'h00;
      dataI = 32'h0;
   endtask

   task automatic idleEdges(input int k);
      idleInputs();
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Counts rising edges until busyO drops, bounded so a stuck sweep still ends.
   task automatic waitIdle(output int cnt);
      cnt = 0;
      idleInputs();
      while (busyO === 1'b1 && cnt < 400) begin
         @(posedge clk);
         #1;
         cnt++;
      end
   endtask

   task automatic resetPulse(input string name);
      #2;
      rst_n = 1'b0;
      #1;
      checkVal({name, ".dataO"}, dataO,          32'h0);
      checkVal({name, ".ackO"},  {31'b0, ackO},  32'h0);
      checkVal({name, ".errO"},  {31'b0, errO},  32'h0);
      checkVal({name, ".busyO"}, {31'b0, busyO}, 32'h1);
      idleInputs();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int cnt;

      vecs[0]  = '{1'b1, 1'b1, 8'h00, 32'h0,        1'b1, 32'h0};
      vecs[1]  = '{1'b1, 1'b1, 8'h7F, 32'h0,        1'b1, 32'h0};
      vecs[2]  = '{1'b1, 1'b1, 8'hFF, 32'h0,        1'b1, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 32'h0};
      vecs[4]  = '{1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 1'b1, 32'h0};
      vecs[5]  = '{1'b1, 1'b1, 8'h10, 32'h0,        1'b1, 32'hDEADBEEF};
      vecs[6]  = '{1'b1, 1'b0, 8'h01, 32'h1,        1'b1, 32'hDEADBEEF};
      vecs[7]  = '{1'b1, 1'b0, 8'h02, 32'h2,        1'b1, 32'hDEADBEEF};
      vecs[8]  = '{1'b1, 1'b0, 8'h03, 32'h3,        1'b1, 32'hDEADBEEF};
      vecs[9]  = '{1'b1, 1'b0, 8'h04, 32'h4,        1'b1, 32'hDEADBEEF};
      vecs[10] = '{1'b1, 1'b1, 8'h01, 32'h0,        1'b1, 32'h1};
      vecs[11] = '{1'b1, 1'b1, 8'h02, 32'h0,        1'b1, 32'h2};
      vecs[12] = '{1'b1, 1'b1, 8'h03, 32'h0,        1'b1, 32'h3};
      vecs[13] = '{1'b1, 1'b1, 8'h04, 32'h0,        1'b1, 32'h4};
      vecs[14] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 32'h4};
      vecs[15] = '{1'b0, 1'b1, 8'h02, 32'h55555555, 1'b0, 32'h4};
      vecs[16] = '{1'b1, 1'b0, 8'hFF, 32'hA5A5A5A5, 1'b1, 32'h4};
      vecs[17] = '{1'b1, 1'b1, 8'h00, 32'h0,        1'b1, 32'h0};
      vecs[18] = '{1'b1, 1'b1, 8'hFF, 32'h0,        1'b1, 32'hA5A5A5A5};
      vecs[19] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 32'hA5A5A5A5};

      rst_n = 1'b0;
      idleInputs();
      repeat (3) @(posedge clk);
      #1;
      checkVal("reset.dataO", dataO,          32'h0);
      checkVal("reset.ackO",  {31'b0, ackO},  32'h0);
      checkVal("reset.busyO", {31'b0, busyO}, 32'h1);
      checkVal("reset.errO",  {31'b0, errO},  32'h0);
      #2;
      rst_n = 1'b1;
      waitIdle(cnt);
      checkVal("initSweep.edges", cnt, 256);

      for (int i = 0; i < 20; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].ce, vecs[i].rw, 1'b0, vecs[i].mar,
                       vecs[i].data, vecs[i].expAck, vecs[i].expData, 1'b0, 1'b0);
         checkOutput();
      end

      // Clear and read on the same idle edge: read dropped, error latched.
      applyStimulus("clrAndRead", 1'b1, 1'b1, 1'b1, 8'h10, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1);
      checkOutput();
      waitIdle(cnt);
      checkVal("clrSweep.edges", cnt, 256);
      applyStimulus("readAfterClr", 1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
      checkOutput();
      applyStimulus("writeFF", 1'b1, 1'b0, 1'b0, 8'hFF, 32'h12345678, 1'b1, 32'h0, 1'b0, 1'b1);
      checkOutput();

      // Restart the sweep at its 100th edge, then poke it with a request.
      applyStimulus("clrStart", 1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput();
      idleEdges(99);
      applyStimulus("clrRestart", 1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput();
      applyStimulus("ceInSweep", 1'b1, 1'b1, 1'b0, 8'hFF, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput();
      waitIdle(cnt);
      checkVal("restartSweep.edges", cnt + 1, 256);
      applyStimulus("readFFAfterRestart", 1'b1, 1'b1, 1'b0, 8'hFF, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
      checkOutput();

      resetPulse("rstIdle");
      idleEdges(49);
      applyStimulus("dropWriteInSweep", 1'b1, 1'b0, 1'b0, 8'h10, 32'hCAFE0000, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput();
      idleEdges(50);
      resetPulse("rstMidSweep");
      waitIdle(cnt);
      checkVal("rstSweep.edges", cnt, 256);
      applyStimulus("readDropped", 1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      checkOutput();
      applyStimulus("write10", 1'b1, 1'b0, 1'b0, 8'h10, 32'hCAFE0001, 1'b1, 32'h0, 1'b0, 1'b0);
      checkOutput();
      applyStimulus("read10", 1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 32'hCAFE0001, 1'b0, 1'b0);
      checkOutput();
      resetPulse("rstMidRead");
      waitIdle(cnt);
      checkVal("rstReadSweep.edges", cnt, 256);
      applyStimulus("read10AfterRst", 1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      checkOutput();
      idleInputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side endpoint of the delayed memory bus: it accepts the address, data, chip-enable, read/write and clear lines after the bus-delay stage and services them against an internal 2^n x m word array. It returns read data with a one-cycle acknowledge, performs multi-cycle clear sweeps, and flags requests dropped while it is busy. It sits downstream of the bus delay line; its outputs feed the processor's memory-data register and stall logic.

## Interface
- n, 8, address width; array depth is 2^n words
- m, 32, data word width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- marI  in  n  request address
- dataI  in  m  write data
- ceI  in  1  chip enable; 1 = request present this cycle
- rwI  in  1  1 = read, 0 = write (valid only when ceI=1)
- clrI  in  1  clear request; zeroes the whole array
- dataO  out  m  last read data (registered)
- ackO  out  1  one-cycle acknowledge per serviced request
- busyO  out  1  high while a clear sweep is in progress
- errO  out  1  sticky: a request was dropped

## Operation
- FSM states: IDLE, CLEAR. Sweep pointer ptr, n bits.
- Reset (rst_n=0, immediate): state=CLEAR, ptr=0, dataO=0, ackO=0, busyO=1, errO=0. Array contents are not reset directly; the forced sweep after release zeroes them.
- CLEAR: each rising edge writes 0 to mem[ptr] and increments ptr. On the edge where ptr=2^n-1 is written, go to IDLE; ptr wraps to 0. busyO=1 throughout CLEAR.
- IDLE, priority per rising edge:
  1. clrI=1: enter CLEAR with ptr=0, no array write this edge. If ceI=1 on the same edge, the request is dropped and errO is set.
  2. ceI=1, rwI=1: dataO <= mem[marI], ackO <= 1.
  3. ceI=1, rwI=0: mem[marI] <= dataI, ackO <= 1. dataO is unchanged.
  4. otherwise ackO <= 0.
- CLEAR with clrI=1: restart the sweep (ptr <= 0) without writing this edge.
- CLEAR with ceI=1 (and clrI=0): the request is dropped, errO <= 1, ackO stays 0, the sweep continues.
- ceI is level-sensitive: one request is serviced per rising edge for as long as it is held high. Back-to-back requests produce ackO high on consecutive cycles.
- errO is cleared only by rst_n.
- rwI and dataI are ignored when ceI=0. marI is ignored in CLEAR.

## Timing
- Inputs are sampled on the rising edge. The upstream delay stage updates on the falling edge, giving half a cycle of setup.
- Read latency is 1: a request sampled at edge k gives dataO and ackO valid after edge k, and ackO falls after edge k+1 unless another request is serviced there.
- Write then read of the same address on consecutive edges returns the new data. There is no bypass within a single edge because there is only one operation per edge.
- After rst_n is released, busyO stays high for exactly 2^n rising edges (256 with defaults). The first request is accepted at edge 2^n+1.
- A clrI accepted in IDLE at edge k makes busyO high from after edge k until after edge k+2^n. Edges k+1 through k+2^n perform the writes.
- Reset asserted mid-sweep or mid-request: outputs go to their reset values immediately, the in-flight ack is lost, and the sweep restarts from 0 after release.

## Test plan
- Release reset, hold ceI=0: busyO=1 for 256 edges then 0. Reading addresses 0x00, 0x7F and 0xFF then gives dataO=0 with ackO pulsing.
- Write 0xDEADBEEF to 0x10, then read 0x10 on the next edge: ackO high two consecutive cycles, and dataO=0xDEADBEEF after the second edge.
- Stream reads of 0x01..0x04 (preloaded 1..4) on consecutive edges: ackO continuously high for 4 cycles, and dataO steps 1,2,3,4 with one-cycle latency.
- Assert clrI and ceI (read 0x10) on the same IDLE edge: ackO=0, errO=1 (sticky), busyO=1 for 256 cycles. A later read of 0x10 returns 0.
- Assert clrI again at sweep edge 100: busyO remains high 256 further edges. A ceI during the sweep sets errO and gives no ackO.
- Pull rst_n low mid-sweep and mid-read: dataO=0, ackO=0, errO=0, busyO=1 immediately, and a full 256-edge sweep follows release.
